serial_sum_deserializer: RTL

//   Receive end of the serial adder datapath. Collects the LSB-first sum bit stream and the

---
 rtl/serial_sum_deserializer.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_sum_deserializer.sv
// Receive end of the serial adder: gathers the LSB-first sum stream and the final carry
// into a parallel word and presents it on a valid/ready handshake.
module serial_sum_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_bit,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum_word,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] sum_word_q, sum_word_d;
    logic             carry_out_q, carry_out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] shifted;

    assign shifted = {sum_bit, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        sum_word_d  = sum_word_q;
        carry_out_d = carry_out_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            S_SHIFT: begin
                err_d = start;
                if (bit_valid) begin
                    shreg_d = shifted;
                    // The counter parks on the last index instead of wrapping.
                    if (cnt_q == LAST_IDX) begin
                        sum_word_d  = shifted;
                        carry_out_d = carry_in;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                err_d = start;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            sum_word_q  <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            sum_word_q  <= sum_word_d;
            carry_out_q <= carry_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign sum_word  = sum_word_q;
    assign carry_out = carry_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
